key_schedule: RTL and testbench
===============================

KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001: The block SHALL have no parameters; it SHALL support AES-128 only (Nk=4, Nr=10, 11 round keys).
REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003: rst_n  input  1  reset, asynchronous and active-low.
REQ-004: start  input  1  request to begin expanding key_in; sampled only in IDLE.
REQ-005: key_in  input  128  cipher key; key_in[127:96] = w0, key_in[31:0] = w3.
REQ-006: rk_valid  output  1  rk_out and rk_idx hold a valid round key.
REQ-007: rk_ready  input  1  downstream (addRoundKey stage) accepts the key when rk_valid & rk_ready.
REQ-008: rk_out  output  128  current round key; same word ordering as key_in.
REQ-009: rk_idx  output  4  index of rk_out, range 0..10.
REQ-010: busy  output  1  high in every state except IDLE.
REQ-011: done  output  1  single-cycle pulse after round key 10 is accepted.

Function
REQ-012: The FSM SHALL have three states: IDLE, EMIT, FINISH.
REQ-013: IDLE with start=1: the block SHALL register key_in as round key 0, set rk_idx=0 and rk_valid=1, and move to EMIT on the next edge.
REQ-014: IDLE with start=0: the block SHALL hold all outputs at their reset values.
REQ-015: EMIT with rk_valid & rk_ready and rk_idx<10: the block SHALL load round key rk_idx+1 on the next edge and keep rk_valid=1, giving one key per cycle under continuous ready.
REQ-016: EMIT with rk_valid & rk_ready and rk_idx=10: the block SHALL clear rk_valid and move to FINISH.
REQ-017: FINISH: the block SHALL assert done for exactly that one cycle, then return to IDLE.
REQ-018: While rk_valid=1 and rk_ready=0, rk_out and rk_idx SHALL hold stable with no limit on stall length.
REQ-019: start SHALL be ignored outside IDLE; key_in SHALL be sampled only on the IDLE start edge.
REQ-020: Next-key computation: t = SubWord(RotWord(w3)) ^ Rcon[i]; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'. All operations are bitwise XOR; there is no arithmetic carry.
REQ-021: RotWord SHALL map bytes {a,b,c,d} to {b,c,d,a}, MSB byte first.
REQ-022: SubWord SHALL apply the FIPS-197 S-box to each of the 4 bytes using 4 internal combinational lookup tables.
REQ-023: Rcon[i] for generating key i=1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 in the MSB byte, with zeros in the other three bytes.
REQ-024: The Rcon sequence SHALL be produced by a register that resets to 01 on each start and advances by xtime (left shift, XOR 1B on carry-out), so that 80 is followed by 1B.
REQ-025: rk_idx SHALL never exceed 10 and SHALL never wrap.
REQ-026: Round key 10 SHALL be the last key emitted; the block SHALL NOT compute or emit a key 11.

Reset
REQ-027: On rst_n=0 the block SHALL immediately, with no clock required, enter IDLE and set rk_valid=0, rk_out=0, rk_idx=0, busy=0, done=0, and the Rcon register to 01.
REQ-028: Reset asserted mid-expansion SHALL abort the expansion; after release the block SHALL emit nothing until a new start.
REQ-029: Reset release SHALL be synchronized externally; the block SHALL take no action in the first cycle after release unless start=1.

Verification
REQ-030: FIPS-197 vector, rk_ready=1: key 2b7e151628aed2a6abf7158809cf4f3c -> idx0 equals the key, idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6, on 11 consecutive cycles, then done=1 for one cycle.
REQ-031: All-zero key -> idx1 62636363626363636263636362636363, idx10 b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-032: Random rk_ready backpressure (stalls of 0-5 cycles) -> rk_out/rk_idx stable during each stall; the key sequence is identical to REQ-030.
REQ-033: start=1 with a different key_in at idx 4 -> ignored; the sequence completes with the original key values.
REQ-034: rst_n=0 at idx 6 -> rk_valid=0 with no clock edge; after release and a new start, idx0 through idx10 are correct with Rcon restarting at 01.
REQ-035: Back-to-back runs: start asserted in the cycle after done -> the second expansion is correct; busy is low for exactly one cycle (IDLE) between runs.

Source files
------------

// File: rtl/key_schedule.sv
// AES-128 round-key generator. Emits round keys 0..10 one at a time over a
// valid/ready handshake and pulses done after key 10 has been accepted.
module key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

  // FIPS-197 S-box; element 0 is the leftmost byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state;
  logic [7:0]   rcon;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  t_word;
  logic [31:0]  w0_next;
  logic [31:0]  w1_next;
  logic [31:0]  w2_next;
  logic [31:0]  w3_next;
  logic [127:0] next_key;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8): 0x80 -> 0x1b, so the Rcon chain never needs a table.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Next round key from the current one: RotWord, SubWord, Rcon, then the XOR chain.
  always_comb begin
    rot_word = {rk_out[23:0], rk_out[31:24]};
    sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
    t_word   = sub_word ^ {rcon, 24'h000000};
    w0_next  = rk_out[127:96] ^ t_word;
    w1_next  = rk_out[95:64]  ^ w0_next;
    w2_next  = rk_out[63:32]  ^ w1_next;
    w3_next  = rk_out[31:0]   ^ w2_next;
    next_key = {w0_next, w1_next, w2_next, w3_next};
  end

  // Control FSM with registered outputs; key and Rcon advance on each accepted key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rcon     <= 8'h01;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rk_out   <= key_in;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            rcon     <= 8'h01;
            state    <= EMIT;
          end else begin
            rk_out   <= '0;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        EMIT: begin
          if (rk_valid && rk_ready) begin
            if (rk_idx != 4'd10) begin
              rk_out <= next_key;
              rk_idx <= rk_idx + 4'd1;
              rcon   <= xtime(rcon);
            end else begin
              // Key 10 is the last one; no key 11 is ever formed.
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= FINISH;
            end
          end
        end
        FINISH: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          rk_out   <= '0;
          rk_idx   <= 4'd0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          rk_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: table-driven runs plus random keys, checked against
// a word-oriented FIPS-197 expansion model whose S-box is derived from GF(2^8).
module tb_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
    int           max_stall;
    int           inject;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] bb  = b[7:0];
      if (b != 0)
        for (int x = 1; x < 256; x++)
          if (gmul(bb, x[7:0]) == 8'h01) inv = x[7:0];
      sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook 44-word expansion; round key r is words 4r..4r+3.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Entered at a negedge with the DUT idle; leaves at the idle negedge after FINISH.
  task automatic run_key(input logic [127:0] key, input logic [127:0] rk1,
                         input logic [127:0] rk10, input bit use_const,
                         input int max_stall, input int inject, input string tag);
    expand(key);
    chk({tag, " idle busy"}, {127'd0, busy}, 128'd0);
    chk({tag, " idle valid"}, {127'd0, rk_valid}, 128'd0);
    start  = 1'b1;
    key_in = key;
    rk_ready = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 11; i++) begin
      int stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      for (int s = 0; s < stall; s++) begin
        rk_ready = 1'b0;
        chk($sformatf("%s stall idx%0d", tag, i), {124'd0, rk_idx}, 128'(i));
        chk($sformatf("%s stall key%0d", tag, i), rk_out, exp_rk[i]);
        chk($sformatf("%s stall valid%0d", tag, i), {127'd0, rk_valid}, 128'd1);
        @(negedge clk);
      end
      rk_ready = 1'b1;
      if (i == inject) begin
        start  = 1'b1;
        key_in = ~key;
      end
      chk($sformatf("%s idx%0d", tag, i), {124'd0, rk_idx}, 128'(i));
      chk($sformatf("%s key%0d", tag, i), rk_out, exp_rk[i]);
      chk($sformatf("%s valid%0d", tag, i), {127'd0, rk_valid}, 128'd1);
      chk($sformatf("%s busy%0d", tag, i), {127'd0, busy}, 128'd1);
      chk($sformatf("%s nodone%0d", tag, i), {127'd0, done}, 128'd0);
      if (use_const && i == 1)  chk({tag, " const key1"}, rk_out, rk1);
      if (use_const && i == 10) chk({tag, " const key10"}, rk_out, rk10);
      @(negedge clk);
      start = 1'b0;
    end
    rk_ready = 1'b0;
    chk({tag, " finish done"}, {127'd0, done}, 128'd1);
    chk({tag, " finish valid"}, {127'd0, rk_valid}, 128'd0);
    chk({tag, " finish busy"}, {127'd0, busy}, 128'd1);
    @(negedge clk);
    chk({tag, " after done"}, {127'd0, done}, 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, -1};
    tbl[1] = '{128'h0, 128'h62636363626363636263636362636363,
               128'hb4ef5bcb3e92e21123e951cf6f8f188e, 0, -1};
    tbl[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 5, -1};
    tbl[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 4};

    rst_n = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset valid", {127'd0, rk_valid}, 128'd0);
    chk("reset out", rk_out, 128'd0);
    chk("reset idx", {124'd0, rk_idx}, 128'd0);
    chk("reset busy", {127'd0, busy}, 128'd0);
    chk("reset done", {127'd0, done}, 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-release idle", {127'd0, rk_valid}, 128'd0);

    // Table runs back to back: each start lands in the cycle after done.
    for (int v = 0; v < 4; v++)
      run_key(tbl[v].key, tbl[v].rk1, tbl[v].rk10, 1'b1, tbl[v].max_stall,
              tbl[v].inject, $sformatf("vec%0d", v));

    // Reset during expansion at index 6.
    start = 1'b1; key_in = tbl[0].key; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("abort at idx", {124'd0, rk_idx}, 128'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("abort valid", {127'd0, rk_valid}, 128'd0);
    chk("abort idx", {124'd0, rk_idx}, 128'd0);
    chk("abort out", rk_out, 128'd0);
    chk("abort busy", {127'd0, busy}, 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort quiet%0d", i), {127'd0, rk_valid}, 128'd0);
      chk($sformatf("abort quiet busy%0d", i), {127'd0, busy}, 128'd0);
    end
    run_key(tbl[0].key, tbl[0].rk1, tbl[0].rk10, 1'b1, 0, -1, "restart");

    // Random keys with random backpressure.
    for (int r = 0; r < 4; r++)
      run_key({$urandom, $urandom, $urandom, $urandom}, '0, '0, 1'b0, 3, -1,
              $sformatf("rand%0d", r));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
